// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-way round-robin arbiter: FSM encoding
// and the default hold limit.
package rr_arbiter4_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam int MAX_HOLD_DEFAULT = 16;
  localparam int HOLD_CNT_W       = 8;

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four requesters and the arbiter.
interface rr_arbiter4_if;

  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       preempt;

  modport master (
    output req,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  preempt
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output preempt
  );

endinterface

// File: rtl/b2to4_decoder.sv
// Combinational 2-to-4 one-hot decoder assembled from two 1-to-2 decodes.
module b2to4_decoder (
  input  logic [1:0] x1_x0,
  output logic [3:0] z3_z0
);

  logic [1:0] hi;
  logic [1:0] lo;

  // Each half is a 1-to-2 decode of one select bit; the outputs are their products.
  assign hi = {x1_x0[1], ~x1_x0[1]};
  assign lo = {x1_x0[0], ~x1_x0[0]};

  assign z3_z0 = {hi[1] & lo[1], hi[1] & lo[0], hi[0] & lo[1], hi[0] & lo[0]};

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four requesters with registered one-hot grant and
// a hold limit that revokes a long-running grant while others are waiting.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input logic          clock,
  input logic          reset_,
  rr_arbiter4_if.slave bus
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(MAX_HOLD);

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            holder;
  logic [1:0]            holder_nxt;
  logic [1:0]            last;
  logic [1:0]            last_nxt;
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic [HOLD_CNT_W-1:0] hold_cnt_nxt;
  logic                  preempt_r;
  logic                  preempt_nxt;
  logic [1:0]            winner;
  logic [3:0]            dec;
  logic                  others;

  // First set request scanning upward from last+1; last itself is checked last.
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = l;
    for (int k = 4; k >= 1; k--) begin
      idx = l + 2'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  b2to4_decoder u_dec (
    .x1_x0 (holder),
    .z3_z0 (dec)
  );

  assign winner = pick_winner(bus.req, last);
  assign others = |(bus.req & ~dec);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state     <= S_IDLE;
      holder    <= 2'd0;
      last      <= 2'd3;
      hold_cnt  <= '0;
      preempt_r <= 1'b0;
    end else begin
      state     <= state_nxt;
      holder    <= holder_nxt;
      last      <= last_nxt;
      hold_cnt  <= hold_cnt_nxt;
      preempt_r <= preempt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    holder_nxt   = holder;
    last_nxt     = last;
    hold_cnt_nxt = hold_cnt;
    preempt_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (|bus.req) begin
          state_nxt    = S_GRANT;
          holder_nxt   = winner;
          last_nxt     = winner;
          hold_cnt_nxt = HOLD_CNT_W'(1);
        end
      end
      S_GRANT: begin
        // A release takes precedence over preemption on the same edge.
        if (!bus.req[holder]) begin
          state_nxt    = S_IDLE;
          holder_nxt   = 2'd0;
          hold_cnt_nxt = '0;
        end else if (hold_cnt == HOLD_LIMIT && others) begin
          state_nxt    = S_IDLE;
          holder_nxt   = 2'd0;
          hold_cnt_nxt = '0;
          preempt_nxt  = 1'b1;
        end else if (hold_cnt != HOLD_LIMIT) begin
          hold_cnt_nxt = hold_cnt + HOLD_CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.gnt_valid = (state == S_GRANT);
  assign bus.gnt_id    = holder;
  assign bus.gnt       = dec & {4{bus.gnt_valid}};
  assign bus.preempt   = preempt_r;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: one arbiter with the default hold limit
// and one with a hold limit of 4, sharing clock and reset.
module tb_rr_arbiter4;

  logic clock;
  logic reset_;
  int   passed;
  int   total;

  rr_arbiter4_if bus();
  rr_arbiter4_if bus4();

  rr_arbiter4 #(.MAX_HOLD(16)) u_dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus.slave)
  );

  rr_arbiter4 #(.MAX_HOLD(4)) u_dut4 (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus4.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_reset();
    reset_ = 1'b0;
    @(negedge clock);
    reset_ = 1'b1;
  endtask

  task automatic test_reset();
    bus.req  = 4'b1111;
    bus4.req = 4'b0000;
    reset_   = 1'b0;
    @(negedge clock);
    @(negedge clock);
    total++; if (bus.gnt !== 4'b0000) $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); else passed++;
    total++; if (bus.gnt_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.gnt_valid); else passed++;
    total++; if (bus.gnt_id !== 2'b00) $display("FAIL reset_id: got %b expected 00", bus.gnt_id); else passed++;
    total++; if (bus.preempt !== 1'b0) $display("FAIL reset_preempt: got %b expected 0", bus.preempt); else passed++;
    reset_ = 1'b1;
    @(negedge clock);
    total++; if (bus.gnt !== 4'b0001) $display("FAIL reset_first_gnt: got %b expected 0001", bus.gnt); else passed++;
    total++; if (bus.gnt_valid !== 1'b1) $display("FAIL reset_first_valid: got %b expected 1", bus.gnt_valid); else passed++;
    bus.req = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_rotation();
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req = 4'b1111;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      total++; if (bus.gnt !== order[i]) $display("FAIL rot_gnt_a[%0d]: got %b expected %b", i, bus.gnt, order[i]); else passed++;
      @(negedge clock);
      total++; if (bus.gnt !== order[i]) $display("FAIL rot_gnt_b[%0d]: got %b expected %b", i, bus.gnt, order[i]); else passed++;
      bus.req = 4'b1111 & ~order[i];
      @(negedge clock);
      total++; if (bus.gnt !== 4'b0000) $display("FAIL rot_gap[%0d]: got %b expected 0000", i, bus.gnt); else passed++;
      bus.req = 4'b1111;
    end
    bus.req = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_single();
    int bad;
    bad = 0;
    bus.req = 4'b0100;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.gnt !== 4'b0100 || bus.preempt !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL single_hold: got %0d bad cycles expected 0", bad); else passed++;
    total++; if (u_dut.hold_cnt !== 8'd16) $display("FAIL single_sat: got %0d expected 16", u_dut.hold_cnt); else passed++;
    bus.req = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_preempt();
    bus.req  = 4'b0000;
    bus4.req = 4'b0011;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      total++; if (bus4.gnt !== 4'b0001 || bus4.preempt !== 1'b0)
        $display("FAIL pre_hold[%0d]: got gnt=%b preempt=%b expected gnt=0001 preempt=0", i, bus4.gnt, bus4.preempt); else passed++;
    end
    @(negedge clock);
    total++; if (bus4.gnt !== 4'b0000) $display("FAIL pre_gap_gnt: got %b expected 0000", bus4.gnt); else passed++;
    total++; if (bus4.preempt !== 1'b1) $display("FAIL pre_pulse: got %b expected 1", bus4.preempt); else passed++;
    @(negedge clock);
    total++; if (bus4.gnt !== 4'b0010) $display("FAIL pre_next_gnt: got %b expected 0010", bus4.gnt); else passed++;
    total++; if (bus4.preempt !== 1'b0) $display("FAIL pre_pulse_width: got %b expected 0", bus4.preempt); else passed++;
    // Holder 1 drops its request on the cycle its counter reaches the limit.
    for (int i = 2; i <= 4; i++) begin
      @(negedge clock);
      total++; if (bus4.gnt !== 4'b0010) $display("FAIL pre_h1[%0d]: got %b expected 0010", i, bus4.gnt); else passed++;
    end
    bus4.req = 4'b0001;
    @(negedge clock);
    total++; if (bus4.gnt !== 4'b0000) $display("FAIL rel_at_limit_gnt: got %b expected 0000", bus4.gnt); else passed++;
    total++; if (bus4.preempt !== 1'b0) $display("FAIL rel_at_limit_preempt: got %b expected 0", bus4.preempt); else passed++;
    @(negedge clock);
    total++; if (bus4.gnt !== 4'b0001) $display("FAIL rel_at_limit_next: got %b expected 0001", bus4.gnt); else passed++;
    bus4.req = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_wrap();
    bus.req = 4'b1001;
    do_reset();
    @(negedge clock);
    total++; if (bus.gnt !== 4'b0001) $display("FAIL wrap_first: got %b expected 0001", bus.gnt); else passed++;
    bus.req = 4'b1000;
    @(negedge clock);
    total++; if (bus.gnt !== 4'b0000) $display("FAIL wrap_gap: got %b expected 0000", bus.gnt); else passed++;
    bus.req = 4'b1001;
    @(negedge clock);
    total++; if (bus.gnt !== 4'b1000) $display("FAIL wrap_second: got %b expected 1000", bus.gnt); else passed++;
    total++; if (bus.gnt_id !== 2'd3) $display("FAIL wrap_id: got %0d expected 3", bus.gnt_id); else passed++;
    bus.req = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_async_reset();
    bus.req = 4'b0100;
    do_reset();
    @(negedge clock);
    total++; if (bus.gnt !== 4'b0100) $display("FAIL async_pre_gnt: got %b expected 0100", bus.gnt); else passed++;
    #2;
    reset_ = 1'b0;
    #1;
    total++; if (bus.gnt !== 4'b0000) $display("FAIL async_gnt: got %b expected 0000", bus.gnt); else passed++;
    total++; if (bus.gnt_valid !== 1'b0) $display("FAIL async_valid: got %b expected 0", bus.gnt_valid); else passed++;
    total++; if (bus.gnt_id !== 2'b00) $display("FAIL async_id: got %b expected 00", bus.gnt_id); else passed++;
    bus.req = 4'b0101;
    @(negedge clock);
    reset_ = 1'b1;
    @(negedge clock);
    total++; if (bus.gnt !== 4'b0001) $display("FAIL async_next_gnt: got %b expected 0001", bus.gnt); else passed++;
    bus.req = 4'b0000;
    @(negedge clock);
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    reset_   = 1'b0;
    bus.req  = 4'b0000;
    bus4.req = 4'b0000;
    test_reset();
    test_rotation();
    test_single();
    test_preempt();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Round-robin arbiter sharing one resource among four requesters. Grants are issued in one-hot code: the winning 2-bit index is registered and expanded by a 2-to-4 decoder. A hold counter preempts a requester that keeps the resource too long while others wait. The arbiter sits in front of any shared datapath element, such as a bus or an ALU, that can serve one client at a time.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles in GRANT for one holder while any other request is pending. Legal range 2..255.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_` in 1: asynchronous, active-low reset.
- `req` in 4: request lines. `req[i]=1` means requester i wants the resource. It is held high until the requester is done.
- `gnt` out 4: one-hot grant, or all zeros.
- `gnt_valid` out 1: 1 while any grant is active; equals the OR of the `gnt` bits.
- `gnt_id` out 2: index of the current holder. Meaningful only when `gnt_valid=1`; 0 otherwise.
- `preempt` out 1: one-cycle pulse on the cycle a grant is revoked because of `MAX_HOLD`.

## Operation
**States**
- IDLE: no grant.
- GRANT: one holder.

**Reset values**
- State IDLE.
- `gnt=0000`, `gnt_valid=0`, `gnt_id=00`, `preempt=0`.
- Last-winner pointer `last=3`, so requester 0 has top priority after reset.
- Hold counter `hold_cnt=0`.

**IDLE**
- If `req!=0`, pick the first set bit scanning `last+1, last+2, ...` modulo 4 (wrap-around).
- Go to GRANT and set `gnt_id` to the winner.
- Set `last` to the winner and `hold_cnt=1`.

**GRANT**
- If `req[gnt_id]=0`, the holder releases: go to IDLE and clear the grant.
- Else if `hold_cnt==MAX_HOLD` and any other `req` bit is set: go to IDLE, clear the grant, pulse `preempt=1`.
- Else stay in GRANT with `hold_cnt=hold_cnt+1`.
  - The counter saturates at `MAX_HOLD`; it never wraps.
  - While the holder is the only requester, the grant is kept indefinitely.

**Fairness and decoding**
- A released or preempted holder has the lowest priority in the next arbitration.
- `gnt` is always the decoder output of `gnt_id`, gated by `gnt_valid`. It never has more than one bit set.

**Boundary conditions**
- Simultaneous requests: resolved by the rotating priority only.
- Holder drops `req` on the same cycle the counter reaches `MAX_HOLD`: treated as a release; `preempt` stays 0.
- Requests changing while in GRANT: no effect until the next arbitration.
- `reset_` low mid-grant: outputs go to their reset values immediately, without waiting for a clock edge; the pointer returns to 3.

## Timing
- Registered outputs; no combinational path from `req` to `gnt`.
- Request latency: `req` high before edge t gives `gnt` at edge t, visible from cycle t+1. The minimum is 1 cycle from IDLE.
- Release latency: holder drops `req` before edge t, so `gnt` clears at edge t.
- Turnaround: after every release or preemption there is exactly one IDLE cycle with `gnt=0000` before the next grant.
  - Back-to-back grants are therefore spaced by at least one cycle.
  - Worst-case wait for a requester with others active is 3·(`MAX_HOLD`+1) cycles.
- `preempt` is high for exactly the one cycle following the revoking edge, which is the IDLE turnaround cycle.

## Structure
- Shared package/header holds the state encodings (`S_IDLE=1'b0`, `S_GRANT=1'b1`) and the default for `MAX_HOLD`.
- Sub-module `b2to4_decoder(x1_x0, z3_z0)`: combinational 2-to-4 one-hot decoder, built in the style of the existing 1-to-2 decoders. It is instantiated once to expand `gnt_id` into `gnt`.
- Next-winner selection is a small combinational priority function of `req` and `last`, inside the arbiter.
- The hold counter is 8 bits wide.

## Test plan
1. **Reset:** `reset_=0` with `req=1111` gives `gnt=0000`, `gnt_valid=0`, `gnt_id=00`. After release of `reset_`, the first edge gives `gnt=0001`.
2. **Rotation:** `req=1111`, each holder drops `req` for 1 cycle after 2 cycles of grant. The grant order is 0001, 0010, 0100, 1000, 0001, with one `gnt=0000` cycle between grants.
3. **Single requester:** `req=0100` held for 100 cycles gives `gnt=0100` throughout, `preempt` never asserted, and the counter saturated at 16.
4. **Preemption:** `MAX_HOLD=4`, `req=0011` held. Requester 0 is granted for 4 cycles, then `preempt=1` with `gnt=0000` for one cycle, then `gnt=0010`.
5. **Wrap-around:** with `last=3`, set `req=1001`; requester 0 wins. After its release with `req=1001` still set, requester 3 wins.
6. **Asynchronous reset mid-grant:** pulse `reset_` low between clock edges while `gnt=0100`. Outputs clear before the next edge, and the next grant with `req=0101` goes to requester 0.
